word_adder: RTL and testbench

- Dictionary word header writer: the write-side counterpart of the dictionary finder.
- On a start pulse, scans a null-terminated name in the terminal input buffer (TIB) over the single-port 8-bit memory bus.
- Appends a header at HERE: 16-bit link field (LFA), length byte, name bytes.
- Returns the new LFA (becomes CONTEXT) and the new HERE, so the finder can locate the word afterwards.

---
 rtl/word_adder.sv | 165 ++++++++++++++++
 tb/tb_word_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_adder.sv
// Dictionary header writer: scans a null-terminated TIB name and appends link, length and name at HERE.
// Optional DICT_CF_EN adds a cf port and writes a 16-bit code field after the name.
module word_adder #(
  parameter int unsigned ASZ  = 17,
  parameter int unsigned DSZ  = 8,
  parameter int unsigned NMAX = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [ASZ-1:0] aw,
  input  logic [15:0]    lfa_i,
  input  logic [ASZ-1:0] here_i,
`ifdef DICT_CF_EN
  input  logic [15:0]    cf,
`endif
  output logic [ASZ-1:0] ma,
  output logic           we,
  output logic [DSZ-1:0] vo,
  input  logic [DSZ-1:0] vi,
  output logic           bsy,
  output logic           done,
  output logic           err,
  output logic [ASZ-1:0] lfa_o,
  output logic [ASZ-1:0] here_o
);

  localparam int unsigned NW = $clog2(NMAX + 1);

  typedef enum logic [3:0] {
    IDLE, RD, CHK, LNK0, LNK1, WR, LEN, CF0, CF1, DONE
  } state_t;

  state_t         st;
  logic [ASZ-1:0] aw_r;
  logic [ASZ-1:0] here_r;
  logic [15:0]    lnk_r;
  logic [NW-1:0]  n;
  logic [DSZ-1:0] ch;
`ifdef DICT_CF_EN
  logic [15:0]    cf_r;
`endif
  logic [ASZ-1:0] pfa_c;

  // Address of the next name byte; after the last name byte it is the parameter field.
  assign pfa_c = here_r + ASZ'(3) + ASZ'(n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      aw_r   <= '0;
      here_r <= '0;
      lnk_r  <= '0;
      n      <= '0;
      ch     <= '0;
`ifdef DICT_CF_EN
      cf_r   <= '0;
`endif
      ma     <= '0;
      we     <= 1'b0;
      vo     <= '0;
      bsy    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      lfa_o  <= '0;
      here_o <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (en) begin
            aw_r   <= aw;
            lnk_r  <= lfa_i;
            here_r <= here_i;
`ifdef DICT_CF_EN
            cf_r   <= cf;
`endif
            err    <= 1'b0;
            n      <= '0;
            bsy    <= 1'b1;
            ma     <= aw;
            st     <= RD;
          end
        end
        RD: st <= CHK;
        CHK: begin
          ch <= vi;
          if (vi == '0 && n == '0) begin
            err  <= 1'b1;
            done <= 1'b1;
            st   <= DONE;
          end else if (vi == '0 || n == NW'(NMAX)) begin
            // Terminator found, or name hit NMAX and is truncated.
            err <= (vi != '0);
            ma  <= here_r + ASZ'(2);
            vo  <= DSZ'(n);
            we  <= 1'b1;
            st  <= LEN;
          end else if (n == '0) begin
            ma <= here_r;
            vo <= DSZ'(lnk_r[7:0]);
            we <= 1'b1;
            st <= LNK0;
          end else begin
            ma <= pfa_c;
            vo <= vi;
            we <= 1'b1;
            st <= WR;
          end
        end
        LNK0: begin
          ma <= here_r + ASZ'(1);
          vo <= DSZ'(lnk_r[15:8]);
          we <= 1'b1;
          st <= LNK1;
        end
        LNK1: begin
          ma <= pfa_c;
          vo <= ch;
          we <= 1'b1;
          st <= WR;
        end
        WR: begin
          n  <= n + NW'(1);
          ma <= aw_r + ASZ'(n) + ASZ'(1);
          st <= RD;
        end
`ifdef DICT_CF_EN
        LEN: begin
          ma <= pfa_c;
          vo <= DSZ'(cf_r[15:8]);
          we <= 1'b1;
          st <= CF0;
        end
        CF0: begin
          ma <= pfa_c + ASZ'(1);
          vo <= DSZ'(cf_r[7:0]);
          we <= 1'b1;
          st <= CF1;
        end
        CF1: begin
          done   <= 1'b1;
          lfa_o  <= here_r;
          here_o <= pfa_c + ASZ'(2);
          st     <= DONE;
        end
`else
        LEN: begin
          done   <= 1'b1;
          lfa_o  <= here_r;
          here_o <= pfa_c;
          st     <= DONE;
        end
`endif
        DONE: begin
          bsy <= 1'b0;
          st  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_adder.sv
// Self-checking bench for word_adder: vector table, random names against a header model, chaining and reset cases.
module tb_word_adder;

  localparam int NMAX = 31;
`ifdef DICT_CF_EN
  localparam int CFX = 2;
`else
  localparam int CFX = 0;
`endif

  typedef struct {
    string       nm;
    logic [16:0] aw;
    logic [15:0] lfa;
    logic [16:0] here;
    logic [15:0] cf;
    logic [16:0] exp_here;
    logic [16:0] exp_lfa;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [16:0] aw;
  logic [15:0] lfa_i;
  logic [16:0] here_i;
`ifdef DICT_CF_EN
  logic [15:0] cf;
`endif
  logic [16:0] ma;
  logic        we;
  logic [7:0]  vo;
  logic [7:0]  vi;
  logic        bsy, done, err;
  logic [16:0] lfa_o, here_o;

  logic [7:0]  mem [0:131071];
  logic        ld_we = 1'b0;
  logic [16:0] ld_a = '0;
  logic [7:0]  ld_d = '0;
  int          wcnt = 0;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  cur [$];
  logic [16:0] prev_lfa = '0;
  logic [16:0] prev_here = '0;

  word_adder dut (
    .clk(clk), .rst(rst), .en(en), .aw(aw), .lfa_i(lfa_i), .here_i(here_i),
`ifdef DICT_CF_EN
    .cf(cf),
`endif
    .ma(ma), .we(we), .vo(vo), .vi(vi), .bsy(bsy), .done(done), .err(err),
    .lfa_o(lfa_o), .here_o(here_o)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (we) mem[ma] <= vo;
    else if (ld_we) mem[ld_a] <= ld_d;
    vi <= mem[ma];
  end

  always @(negedge clk) if (we) wcnt <= wcnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_byte(input logic [16:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic set_name(input string s);
    cur.delete();
    for (int i = 0; i < s.len(); i++) cur.push_back(8'(s[i]));
  endtask

  function automatic vec_t mk(string nm, int a, int l, int h, int c, int eh, int el, int ee, int lat);
    vec_t v;
    v.nm = nm; v.aw = 17'(a); v.lfa = 16'(l); v.here = 17'(h); v.cf = 16'(c);
    v.exp_here = 17'(eh); v.exp_lfa = 17'(el); v.exp_err = 1'(ee); v.exp_lat = lat;
    return v;
  endfunction

  // Walk the link chain from ctx looking for name s (link value ffff ends the chain).
  function automatic bit find(string s, logic [16:0] ctx);
    logic [16:0] p;
    bit m;
    p = ctx;
    for (int k = 0; k < 16; k++) begin
      if (p[15:0] == 16'hffff) return 1'b0;
      if (int'(mem[p + 17'(2)][4:0]) == s.len()) begin
        m = 1'b1;
        for (int i = 0; i < s.len(); i++)
          if (mem[p + 17'(3 + i)] != 8'(s[i])) m = 1'b0;
        if (m) return 1'b1;
      end
      p = {1'b0, mem[p + 17'(1)], mem[p]};
    end
    return 1'b0;
  endfunction

  // Run one header write of cur[] and check outputs, latency, write count and memory image.
  task automatic run_case(input string tag, input logic [16:0] a, input logic [15:0] l,
                          input logic [16:0] h, input logic [15:0] c, input bit poke,
                          input logic [16:0] eh, input logic [16:0] el, input logic ee, input int elat);
    int len, nl, cyc, w0, bad;
    logic [7:0] hb [$];
    len = cur.size();
    nl = (len > NMAX) ? NMAX : len;
    for (int i = 0; i < len; i++) load_byte(a + 17'(i), cur[i]);
    load_byte(a + 17'(len), 8'h00);
    aw = a; lfa_i = l; here_i = h;
`ifdef DICT_CF_EN
    cf = c;
`endif
    w0 = wcnt;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    aw = 17'($urandom); lfa_i = 16'($urandom); here_i = 17'($urandom);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      en = poke && (cyc == 3);
    end
    en = 1'b0;
    chk({tag, " lat"}, 64'(cyc), 64'(elat));
    chk({tag, " err"}, 64'(err), 64'(ee));
    chk({tag, " lfa_o"}, 64'(lfa_o), 64'(el));
    chk({tag, " here_o"}, 64'(here_o), 64'(eh));
    chk({tag, " bsy@done"}, 64'(bsy), 64'd1);
    chk({tag, " writes"}, 64'(wcnt - w0), 64'((len == 0) ? 0 : 3 + nl + CFX));
    @(posedge clk); #1;
    chk({tag, " idle"}, {62'd0, done, bsy}, 64'd0);
    chk({tag, " err hold"}, 64'(err), 64'(ee));
    if (len > 0) begin
      hb.push_back(l[7:0]); hb.push_back(l[15:8]); hb.push_back(8'(nl));
      for (int i = 0; i < nl; i++) hb.push_back(cur[i]);
      if (CFX != 0) begin hb.push_back(c[15:8]); hb.push_back(c[7:0]); end
      bad = 0;
      for (int i = 0; i < hb.size(); i++)
        if (mem[h + 17'(i)] !== hb[i]) bad++;
      chk({tag, " hdr bytes bad"}, 64'(bad), 64'd0);
    end
    prev_lfa = el; prev_here = eh;
  endtask

  initial begin
    vec_t vt [5];
    logic [16:0] a, h, eh, el;
    logic [15:0] l, c;
    int len, nl;
    string chain [4];

    vt[0] = mk("abcd", 'h0, 'hffff, 'h10, 'hbeef, 'h17 + CFX, 'h10, 0, 17 + CFX);
    vt[1] = mk("x", 'h40, 'h1234, 'h100, 'h0102, 'h104 + CFX, 'h100, 0, 8 + CFX);
    vt[2] = mk("hi", 'h800, 'h00a5, 'h1fffe, 'h5a5a, 'h3 + CFX, 'h1fffe, 0, 11 + CFX);
    vt[3] = mk("", 'h60, 'h4444, 'h300, 'h0, 'h3 + CFX, 'h1fffe, 1, 2);
    vt[4] = mk("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn", 'hA00, 'h0777, 'h400, 'hcafe,
               'h422 + CFX, 'h400, 1, 98 + CFX);

    rst = 1'b1; en = 1'b0; aw = '0; lfa_i = '0; here_i = '0;
`ifdef DICT_CF_EN
    cf = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {ma, we, vo, bsy, done, err, lfa_o, here_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", {61'd0, we, bsy, done}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      set_name(vt[i].nm);
      run_case($sformatf("vec%0d", i), vt[i].aw, vt[i].lfa, vt[i].here, vt[i].cf, 1'b0,
               vt[i].exp_here, vt[i].exp_lfa, vt[i].exp_err, vt[i].exp_lat);
    end

    // Reset during the write of the third name character, then a clean rerun.
    set_name("wxyz");
    for (int i = 0; i < 4; i++) load_byte(17'h900 + 17'(i), cur[i]);
    load_byte(17'h904, 8'h00);
    aw = 17'h900; lfa_i = 16'h1111; here_i = 17'h600;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("wr3 we", 64'(we), 64'd1);
    chk("wr3 ma", 64'(ma), 64'h605);
    chk("wr3 vo", 64'(vo), 64'h79);
    rst = 1'b1;
    #1;
    chk("midrun reset outs", {ma, we, vo, bsy, done, err, lfa_o, here_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_lfa = '0; prev_here = '0;
    run_case("after reset", 17'h900, 16'h1111, 17'h600, 16'h2222, 1'b0,
             17'h607 + 17'(CFX), 17'h600, 1'b0, 17 + CFX);

    // Random names; some runs also pulse en while busy, which must be ignored.
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(0, 40);
      cur.delete();
      for (int j = 0; j < len; j++) cur.push_back(8'($urandom_range(1, 255)));
      a = 17'($urandom_range(0, 'hfff));
      h = 17'($urandom_range('h2000, 'h1ff00));
      l = 16'($urandom); c = 16'($urandom);
      nl = (len > NMAX) ? NMAX : len;
      eh = (len == 0) ? prev_here : h + 17'(3 + nl + CFX);
      el = (len == 0) ? prev_lfa : h;
      run_case($sformatf("rnd%0d", r), a, l, h, c, (r % 3) == 0, eh, el,
               (len == 0) || (len > NMAX), (len == 0) ? 2 : 3 * nl + 5 + CFX);
    end

    // Chain four words, feeding each new LFA/HERE into the next, then look one up.
    chain[0] = "abcd"; chain[1] = "efgh"; chain[2] = "ijkl"; chain[3] = "mnop";
    l = 16'hffff; h = 17'h10;
    for (int i = 0; i < 4; i++) begin
      set_name(chain[i]);
      eh = h + 17'(7 + CFX);
      run_case({"chain ", chain[i]}, 17'h80, l, h, 16'h1000 + 16'(i), 1'b0, eh, h, 1'b0, 17 + CFX);
      l = h[15:0]; h = eh;
    end
    chk("find abcd", 64'(find("abcd", {1'b0, l})), 64'd1);
    chk("find mnop", 64'(find("mnop", {1'b0, l})), 64'd1);
    chk("find qrst", 64'(find("qrst", {1'b0, l})), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
